// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the MIPS instruction-fetch queue: FSM encoding,
// word size and the default reset vector.
package mips_fetch_pkg;

   typedef enum logic {
      FETCH = 1'b0,
      DROP  = 1'b1
   } fetch_state_t;

   localparam logic [31:0] WORD_BYTES       = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // Word-align an address; masking keeps every input bit in the expression.
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/mips_fetch_fifo.sv
// DEPTH x 64-bit prefetch FIFO holding {pc, inst}. The head output holds its
// last shown value while the FIFO is empty, including across a flush.
module mips_fetch_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [63:0]              push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count,
   output logic [63:0]              head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [63:0]   mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [63:0]   hold_q;

   // NOTE: storage has no reset; count alone decides which entries are live.
   always_ff @(posedge clock) begin
      if (push && !flush) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         hold_q <= '0;
      end else begin
         hold_q <= head;
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
         end
      end
   end

   assign head = (count != '0) ? mem[rd_ptr] : hold_q;

endmodule

// File: rtl/mips_fetch_queue.sv
// Instruction-fetch stage: sequential req/ack fetch into a prefetch queue,
// valid/ready delivery to the core, and redirect with orphan-request drop.
module mips_fetch_queue
   import mips_fetch_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clock,
   input  logic        reset_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   input  logic        redirect,
   input  logic [31:0] redirect_pc
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t  state_q, state_n;
   logic [31:0]   fetch_pc_q, fetch_pc_n;
   logic [31:0]   drop_addr_q, drop_addr_n;
   logic          run_q;

   logic          push;
   logic          pop;
   logic [CW-1:0] count;
   logic [63:0]   head;

   // run_q keeps imem_req low for the first cycle out of reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= FETCH;
         fetch_pc_q  <= RESET_PC;
         drop_addr_q <= RESET_PC;
         run_q       <= 1'b0;
      end else begin
         state_q     <= state_n;
         fetch_pc_q  <= fetch_pc_n;
         drop_addr_q <= drop_addr_n;
         run_q       <= 1'b1;
      end
   end

   // Memory-side outputs depend on registered state only.
   always_comb begin
      imem_req  = run_q & ((state_q == DROP) | (count < CW'(DEPTH)));
      imem_addr = (state_q == DROP) ? drop_addr_q : fetch_pc_q;
   end

   // NOTE: every output of this block is defaulted first so no path infers a latch.
   always_comb begin
      state_n     = state_q;
      fetch_pc_n  = fetch_pc_q;
      drop_addr_n = drop_addr_q;
      push        = 1'b0;
      if (redirect) begin
         fetch_pc_n = align_word(redirect_pc);
         if (state_q == FETCH && imem_req && !imem_ack) begin
            drop_addr_n = imem_addr;
            state_n     = DROP;
         end else if (state_q == DROP && imem_ack) begin
            // The orphan completes this cycle; no need to re-issue it.
            state_n = FETCH;
         end
      end else if (imem_req && imem_ack) begin
         if (state_q == FETCH) begin
            push       = 1'b1;
            fetch_pc_n = fetch_pc_q + WORD_BYTES;
         end else begin
            state_n = FETCH;
         end
      end
   end

   assign inst_valid = (count != '0);
   assign pop        = inst_valid & inst_ready & ~redirect;
   assign inst_pc    = head[63:32];
   assign inst_data  = head[31:0];

   mips_fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (push),
      .push_data ({fetch_pc_q, imem_rdata}),
      .pop       (pop),
      .flush     (redirect),
      .count     (count),
      .head      (head)
   );

endmodule

// File: tb/tb_mips_fetch_queue.sv
// Self-checking bench for mips_fetch_queue: directed scenarios plus a random
// run, against an instruction-stream model and a memory handshake monitor.
module tb_mips_fetch_queue;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] KEY      = 32'hA5A5_A5A5;

   logic        clock;
   logic        reset_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        redirect;
   logic [31:0] redirect_pc;

   int checks   = 0;
   int failures = 0;
   int consumed = 0;
   int mem_lat  = 0;
   int wait_cnt;

   mips_fetch_queue #(
      .DEPTH    (4),
      .RESET_PC (RESET_PC)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .inst_data   (inst_data),
      .inst_pc     (inst_pc),
      .redirect    (redirect),
      .redirect_pc (redirect_pc)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Memory: acks after mem_lat wait cycles (0 = same cycle); data is a
   // function of the address so any word can be checked against its pc.
   always_comb begin
      imem_ack   = imem_req && (wait_cnt >= mem_lat);
      imem_rdata = imem_addr ^ KEY;
   end

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n)                  wait_cnt <= 0;
      else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
      else                           wait_cnt <= 0;
   end

   // Reference: the core must see pcs RESET_PC, +4, ... restarting at each
   // aligned redirect target; a request must hold until acked.
   logic [31:0] exp_pc;
   logic [31:0] prev_addr;
   logic        prev_req;
   logic        prev_ack;

   always @(negedge clock) begin
      if (!reset_n) begin
         exp_pc   = RESET_PC;
         prev_req = 1'b0;
         prev_ack = 1'b0;
      end else begin
         if (prev_req && !prev_ack) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
               failures++;
               $display("FAIL req_hold: req=%b addr=%h, required req=1 addr=%h",
                        imem_req, imem_addr, prev_addr);
            end
         end
         if (inst_valid === 1'b1 && inst_ready && !redirect) begin
            checks++;
            if (inst_pc !== exp_pc || inst_data !== (exp_pc ^ KEY)) begin
               failures++;
               $display("FAIL stream: pc=%h data=%h, required pc=%h data=%h",
                        inst_pc, inst_data, exp_pc, exp_pc ^ KEY);
            end
            exp_pc = exp_pc + 32'd4;
            consumed++;
         end
         if (redirect) exp_pc = redirect_pc & 32'hFFFF_FFFC;
         prev_req  = imem_req;
         prev_ack  = imem_ack;
         prev_addr = imem_addr;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_reset();
      reset_n  = 1'b0;
      redirect = 1'b0;
      repeat (2) tick();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n     = 1'b0;
      inst_ready  = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      mem_lat     = 0;
      tick();
      checks++;
      if (imem_req !== 1'b0 || imem_addr !== RESET_PC || inst_valid !== 1'b0 ||
          inst_data !== 32'h0 || inst_pc !== 32'h0) begin
         failures++;
         $display("FAIL reset_values: req=%b addr=%h valid=%b data=%h pc=%h, required 0 %h 0 0 0",
                  imem_req, imem_addr, inst_valid, inst_data, inst_pc, RESET_PC);
      end
   endtask

   task automatic test_zero_wait();
      int cyc;
      mem_lat    = 0;
      inst_ready = 1'b1;
      apply_reset();
      cyc = 0;
      while (inst_valid !== 1'b1 && cyc < 10) begin
         tick();
         cyc++;
      end
      checks++;
      if (cyc != 2) begin
         failures++;
         $display("FAIL first_valid_latency: got %0d cycles, required 2", cyc);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * i) || inst_data !== (32'(4 * i) ^ KEY)) begin
            failures++;
            $display("FAIL zero_wait_seq: valid=%b pc=%h data=%h, required 1 %h %h",
                     inst_valid, inst_pc, inst_data, 32'(4 * i), 32'(4 * i) ^ KEY);
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      int pushes;
      int start;
      mem_lat    = 0;
      inst_ready = 1'b0;
      apply_reset();
      pushes = 0;
      for (int i = 0; i < 10; i++) begin
         if (imem_req && imem_ack) pushes++;
         tick();
      end
      checks++;
      if (pushes != 4 || imem_req !== 1'b0 || imem_addr !== 32'h10 ||
          inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
         failures++;
         $display("FAIL full_stall: pushes=%0d req=%b addr=%h valid=%b pc=%h, required 4 0 00000010 1 00000000",
                  pushes, imem_req, imem_addr, inst_valid, inst_pc);
      end
      inst_ready = 1'b1;
      start = consumed;
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
         failures++;
         $display("FAIL resume_after_pop: req=%b addr=%h, required 1 00000010", imem_req, imem_addr);
      end
      repeat (11) tick();
      checks++;
      if (consumed - start != 12) begin
         failures++;
         $display("FAIL drain_throughput: consumed %0d in 12 cycles, required 12", consumed - start);
      end
   endtask

   task automatic test_redirect_pending();
      int cyc;
      mem_lat    = 2;
      inst_ready = 1'b0;
      apply_reset();
      cyc = 0;
      while (!(imem_req === 1'b1 && imem_addr === 32'h8 && imem_ack === 1'b0) && cyc < 50) begin
         tick();
         cyc++;
      end
      checks++;
      if (cyc >= 50) begin
         failures++;
         $display("FAIL wait_req_8: timed out after %0d cycles, required pending request to 00000008", cyc);
      end
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0103;
      tick();
      redirect = 1'b0;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h8 || inst_valid !== 1'b0) begin
         failures++;
         $display("FAIL drop_hold: req=%b addr=%h valid=%b, required 1 00000008 0",
                  imem_req, imem_addr, inst_valid);
      end
      cyc = 0;
      while (imem_ack !== 1'b1 && cyc < 20) begin
         tick();
         cyc++;
      end
      checks++;
      if (cyc >= 20) begin
         failures++;
         $display("FAIL drop_ack: timed out after %0d cycles, required ack", cyc);
      end
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
         failures++;
         $display("FAIL target_req: req=%b addr=%h, required 1 00000100", imem_req, imem_addr);
      end
      cyc = 0;
      while (inst_valid !== 1'b1 && cyc < 20) begin
         tick();
         cyc++;
      end
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst_data !== (32'h100 ^ KEY)) begin
         failures++;
         $display("FAIL target_head: valid=%b pc=%h data=%h, required 1 00000100 %h",
                  inst_valid, inst_pc, inst_data, 32'h100 ^ KEY);
      end
      inst_ready = 1'b1;
      repeat (10) tick();
   endtask

   task automatic test_redirect_ack();
      logic [31:0] target;
      mem_lat    = 0;
      inst_ready = 1'b1;
      apply_reset();
      repeat (6) tick();
      target = $urandom & 32'hFFFF_FFFC;
      checks++;
      if (imem_req !== 1'b1 || imem_ack !== 1'b1 || inst_valid !== 1'b1) begin
         failures++;
         $display("FAIL redirect_ack_setup: req=%b ack=%b valid=%b, required 1 1 1",
                  imem_req, imem_ack, inst_valid);
      end
      redirect    = 1'b1;
      redirect_pc = target | 32'($urandom_range(0, 3));
      tick();
      redirect = 1'b0;
      checks++;
      if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== target) begin
         failures++;
         $display("FAIL redirect_ack_flush: valid=%b req=%b addr=%h, required 0 1 %h",
                  inst_valid, imem_req, imem_addr, target);
      end
      tick();
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== target) begin
         failures++;
         $display("FAIL redirect_ack_head: valid=%b pc=%h, required 1 %h", inst_valid, inst_pc, target);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_seq [3];
      exp_seq[0] = 32'hFFFF_FFF8;
      exp_seq[1] = 32'hFFFF_FFFC;
      exp_seq[2] = 32'h0000_0000;
      mem_lat    = 0;
      inst_ready = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFF8;
      tick();
      redirect = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (inst_valid !== 1'b1 || inst_pc !== exp_seq[i]) begin
            failures++;
            $display("FAIL wrap_seq: valid=%b pc=%h, required 1 %h", inst_valid, inst_pc, exp_seq[i]);
         end
      end
   endtask

   task automatic test_async_reset();
      int cyc;
      mem_lat    = 0;
      inst_ready = 1'b1;
      repeat (5) tick();
      #3;
      reset_n = 1'b0;
      #1;
      checks++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b0 || imem_addr !== RESET_PC) begin
         failures++;
         $display("FAIL async_reset: req=%b valid=%b addr=%h, required 0 0 %h",
                  imem_req, inst_valid, imem_addr, RESET_PC);
      end
      repeat (2) tick();
      reset_n = 1'b1;
      cyc = 0;
      while (inst_valid !== 1'b1 && cyc < 10) begin
         tick();
         cyc++;
      end
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== RESET_PC || cyc != 2) begin
         failures++;
         $display("FAIL restart_after_reset: valid=%b pc=%h cycles=%0d, required 1 %h 2",
                  inst_valid, inst_pc, cyc, RESET_PC);
      end
   endtask

   task automatic test_random();
      int start;
      apply_reset();
      start = consumed;
      for (int i = 0; i < 3000; i++) begin
         inst_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 63) == 0) mem_lat = $urandom_range(0, 3);
         redirect    = ($urandom_range(0, 24) == 0);
         redirect_pc = $urandom;
         tick();
      end
      redirect = 1'b0;
      checks++;
      if (consumed - start < 200) begin
         failures++;
         $display("FAIL random_progress: consumed %0d, required at least 200", consumed - start);
      end
   endtask

   initial begin
      reset_n     = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      inst_ready  = 1'b0;
      test_reset();
      test_zero_wait();
      test_backpressure();
      test_redirect_pending();
      test_redirect_ack();
      test_wrap();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
